// File: rtl/instruction_fetch_pkg.sv
// riscv_definitions: shared fetch types (PC select encoding, instruction word, fetch FSM states).
package riscv_definitions;
    typedef enum logic [1:0] {
        PC_PLUS4 = 2'b00,
        JUMP     = 2'b01,
        TRAP     = 2'b10
    } nextPCType_e;

    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } r_type_t;

    typedef union packed {
        logic [31:0] raw;
        r_type_t     r;
    } instruction_u;

    typedef enum logic [1:0] {F_IDLE, F_RUN, F_DRAIN} fetchState_e;
endpackage

// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if: imem request/response channel and decode handshake bundle.
interface instruction_fetch_if;
    import riscv_definitions::*;
    logic         imem_req, imem_gnt, imem_rvalid, id_valid, id_ready;
    logic [31:0]  imem_addr, imem_rdata, id_pc;
    instruction_u id_inst;
    modport master (output imem_req, imem_addr, id_valid, id_inst, id_pc,
                    input  imem_gnt, imem_rvalid, imem_rdata, id_ready);
    modport slave  (input  imem_req, imem_addr, id_valid, id_inst, id_pc,
                    output imem_gnt, imem_rvalid, imem_rdata, id_ready);
endinterface

// File: rtl/instruction_fetch_buffer.sv
// fetch_buffer: 2-entry FIFO with flush; push and pop may coincide even when full.
module fetch_buffer #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_flush,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_data,
    output logic [1:0]   o_count
);
    logic [W-1:0] r_mem [2];
    logic         r_wp, r_rp;
    logic [1:0]   r_count;
    logic         w_push, w_pop;

    assign w_pop  = i_pop && r_count != 2'd0;
    assign w_push = i_push && (r_count != 2'd2 || w_pop);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_mem   <= '{default: '0};
            r_wp    <= 1'b0;
            r_rp    <= 1'b0;
            r_count <= 2'd0;
        end else if (i_flush) begin
            r_wp    <= 1'b0;
            r_rp    <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) r_mem[r_wp] <= i_data;
            r_wp    <= r_wp ^ w_push;
            r_rp    <= r_rp ^ w_pop;
            r_count <= r_count + 2'(w_push) - 2'(w_pop);
        end

    assign o_data  = r_mem[r_rp];
    assign o_count = r_count;
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: in-order fetch unit with a 2-entry decode buffer and redirect drain.
// IFETCH_MISALIGN_CHECK_EN: trap misaligned JUMP targets instead of forcing word alignment.
module instruction_fetch
    import riscv_definitions::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_PC  = 32'h0000_0004
) (
    input  logic                clk,
    input  logic                rst_n,
    input  nextPCType_e         i_next_pc_sel,
    input  logic [31:0]         i_jump_addr,
    output logic                o_fetch_misaligned,
    instruction_fetch_if.master bus
);
    fetchState_e r_state, w_state_nxt;
    logic [31:0] r_pc, w_target, w_tag;
    logic [1:0]  r_out, w_out_nxt, w_count;
    logic        r_mis, w_mis, w_redirect, w_accept, w_resp, w_push, w_pop;
    logic [63:0] w_head;

    assign w_redirect = i_next_pc_sel != PC_PLUS4;
`ifdef IFETCH_MISALIGN_CHECK_EN
    assign w_mis    = i_next_pc_sel == JUMP && i_jump_addr[1:0] != 2'b00;
    assign w_target = (i_next_pc_sel[1] || w_mis) ? TRAP_PC : i_jump_addr;
`else
    assign w_mis    = 1'b0;
    assign w_target = i_next_pc_sel[1] ? TRAP_PC : i_jump_addr & ~32'd3;
`endif

    assign w_pop = bus.id_valid && bus.id_ready;
    // a slot freed by this cycle's pop may be refilled, keeping issue back-to-back
    assign bus.imem_req  = r_state == F_RUN && !w_redirect &&
                           (3'(r_out) + 3'(w_count) - 3'(w_pop)) < 3'd2;
    assign bus.imem_addr = r_pc;
    assign w_accept  = bus.imem_req && bus.imem_gnt;
    assign w_resp    = bus.imem_rvalid && r_out != 2'd0;
    assign w_push    = w_resp && r_state == F_RUN && !w_redirect;
    assign w_out_nxt = r_out + 2'(w_accept) - 2'(w_resp);
    // in RUN every outstanding request is a consecutive word below pc, oldest first
    assign w_tag = r_pc - 32'({r_out, 2'b00});

    fetch_buffer #(.W(64)) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_redirect),
        .i_data  ({w_tag, bus.imem_rdata}),
        .o_data  (w_head),
        .o_count (w_count)
    );

    assign bus.id_valid = w_count != 2'd0;
    assign bus.id_pc    = w_head[63:32];
    assign bus.id_inst  = w_head[31:0];
    assign o_fetch_misaligned = r_mis;

    always_comb begin
        w_state_nxt = r_state;
        if (w_redirect) w_state_nxt = w_out_nxt != 2'd0 ? F_DRAIN : F_RUN;
        else if (r_state == F_IDLE || (r_state == F_DRAIN && w_out_nxt == 2'd0)) w_state_nxt = F_RUN;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_state <= F_IDLE;
            r_pc    <= RESET_PC;
            r_out   <= 2'd0;
            r_mis   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_redirect ? w_target : w_accept ? r_pc + 32'd4 : r_pc;
            r_out   <= w_out_nxt;
            r_mis   <= w_mis;
        end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: randomized fetch traffic checked against a queue-based memory/decode model.
module tb_instruction_fetch;
    import riscv_definitions::*;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] TRP_PC = 32'h0000_0004;

    logic        clk = 1'b0, rst_n = 1'b0, mis;
    nextPCType_e sel;
    logic [31:0] jaddr;
    instruction_fetch_if bus();

    instruction_fetch #(.RESET_PC(RST_PC), .TRAP_PC(TRP_PC)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .i_next_pc_sel      (sel),
        .i_jump_addr        (jaddr),
        .o_fetch_misaligned (mis),
        .bus                (bus)
    );

    always #5 clk = ~clk;

    typedef struct {logic [31:0] addr; int due; bit drop;} req_t;
    typedef struct {logic [31:0] pc; logic [31:0] inst;} ent_t;
    req_t        mem_q[$];
    ent_t        fifo[$];
    logic [31:0] acc_log[$];
    int          acc_cyc[$];
    logic [31:0] pc;
    bit          started, exp_mis, stray;
    int          cyc, n_assert, n_fail;
    int          gnt_pct = 100, rdy_pct = 100, lat_lo = 1, lat_hi = 1;

    function automatic logic [31:0] inst_of(logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [1:0] s, input logic [31:0] ja);
        bit redir, pop, rv, exp_req;
        req_t h;
        ent_t e;
        sel = nextPCType_e'(s);
        jaddr = ja;
        bus.imem_gnt = $urandom_range(99) < gnt_pct;
        bus.id_ready = $urandom_range(99) < rdy_pct;
        rv = stray || (mem_q.size() != 0 && mem_q[0].due <= cyc);
        bus.imem_rvalid = rv;
        bus.imem_rdata = (rv && mem_q.size() != 0) ? inst_of(mem_q[0].addr) : $urandom;
        #1;
        redir = s != 2'b00;
        pop = fifo.size() != 0 && bus.id_ready;
        exp_req = started && !redir && (mem_q.size() + fifo.size() - int'(pop)) < 2;
        foreach (mem_q[i]) if (mem_q[i].drop) exp_req = 0;
        chk("imem_req", bus.imem_req, exp_req);
        chk("imem_addr", bus.imem_addr, pc);
        chk("id_valid", bus.id_valid, fifo.size() != 0);
        if (fifo.size() != 0) begin
            chk("id_pc", bus.id_pc, fifo[0].pc);
            chk("id_inst", bus.id_inst, fifo[0].inst);
        end
        chk("fetch_misaligned", mis, exp_mis);
        if (bus.imem_req && bus.imem_gnt) begin
            acc_log.push_back(bus.imem_addr);
            acc_cyc.push_back(cyc);
        end
        if (pop) void'(fifo.pop_front());
        if (rv && mem_q.size() != 0) begin
            h = mem_q.pop_front();
            if (!h.drop && !redir) begin
                e.pc = h.addr;
                e.inst = inst_of(h.addr);
                fifo.push_back(e);
            end
        end
        if (exp_req && bus.imem_gnt) begin
            h.addr = pc;
            h.due = cyc + $urandom_range(lat_hi, lat_lo);
            h.drop = 0;
            mem_q.push_back(h);
            pc = pc + 32'd4;
        end
        exp_mis = 0;
        if (redir) begin
            pc = s[1] ? TRP_PC : {ja[31:2], 2'b00};
`ifdef IFETCH_MISALIGN_CHECK_EN
            if (s == 2'b01 && ja[1:0] != 2'b00) begin
                pc = TRP_PC;
                exp_mis = 1;
            end
`endif
            fifo.delete();
            foreach (mem_q[i]) mem_q[i].drop = 1;
        end
        started = 1;
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sel = PC_PLUS4;
        bus.imem_gnt = 1'b0;
        bus.imem_rvalid = 1'b0;
        #1;
        chk("rst_imem_req", bus.imem_req, 0);
        chk("rst_imem_addr", bus.imem_addr, RST_PC);
        chk("rst_id_valid", bus.id_valid, 0);
        chk("rst_id_inst", bus.id_inst, 0);
        chk("rst_id_pc", bus.id_pc, 0);
        chk("rst_misaligned", mis, 0);
        mem_q.delete();
        fifo.delete();
        pc = RST_PC;
        started = 0;
        exp_mis = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_valid(string tag);
        int i = 0;
        while (!bus.id_valid && i < 30) begin
            step(2'b00, 0);
            i++;
        end
        chk(tag, bus.id_valid, 1);
    endtask

    function automatic logic [31:0] acc_at(int idx);
        return acc_log.size() > idx ? acc_log[idx] : 32'hxxxx_xxxx;
    endfunction

    initial begin
        int mark;
        logic [1:0] s;
        logic [31:0] ja;
        sel = PC_PLUS4;
        jaddr = 0;
        bus.imem_gnt = 0;
        bus.imem_rvalid = 0;
        bus.imem_rdata = 0;
        bus.id_ready = 0;
        do_reset();
        // stray rvalid during the IDLE cycle must be ignored
        stray = 1;
        step(2'b00, 0);
        stray = 0;
        repeat (8) step(2'b00, 0);
        chk("burst_addr0", acc_at(0), 32'h0);
        chk("burst_addr1", acc_at(1), 32'h4);
        chk("burst_addr2", acc_at(2), 32'h8);
        chk("burst_back2back", (acc_cyc.size() > 2) ? acc_cyc[2] - acc_cyc[0] : -1, 2);

        rdy_pct = 0;
        mark = acc_log.size();
        repeat (10) step(2'b00, 0);
        chk("stall_accept_le2", (acc_log.size() - mark) <= 2, 1);
        chk("stall_req_low", bus.imem_req, 0);
        rdy_pct = 100;
        repeat (6) step(2'b00, 0);

        lat_lo = 4;
        lat_hi = 4;
        for (int i = 0; i < 20 && mem_q.size() < 2; i++) step(2'b00, 0);
        mark = acc_log.size();
        step(2'b01, 32'h100);
        lat_lo = 1;
        lat_hi = 1;
        wait_valid("jump_valid");
        chk("jump_first_addr", acc_at(mark), 32'h100);
        chk("jump_id_pc", bus.id_pc, 32'h100);

        mark = acc_log.size();
        step(2'b11, 32'h5555_0000);
        chk("trap_fifo_empty", bus.id_valid, 0);
        wait_valid("trap_valid");
        chk("trap_first_addr", acc_at(mark), TRP_PC);

        mark = acc_log.size();
        step(2'b01, 32'h102);
`ifdef IFETCH_MISALIGN_CHECK_EN
        chk("misalign_pulse", mis, 1);
        wait_valid("misalign_valid");
        chk("misalign_addr", acc_at(mark), TRP_PC);
`else
        chk("misalign_pulse", mis, 0);
        wait_valid("misalign_valid");
        chk("misalign_addr", acc_at(mark), 32'h100);
`endif

        mark = acc_log.size();
        step(2'b01, 32'hFFFF_FFFC);
        repeat (4) step(2'b00, 0);
        chk("wrap_addr_top", acc_at(mark), 32'hFFFF_FFFC);
        chk("wrap_addr_zero", acc_at(mark + 1), 32'h0);

        gnt_pct = 70;
        rdy_pct = 70;
        lat_hi = 3;
        repeat (400) begin
            int r = $urandom_range(99);
            s = r < 3 ? 2'b01 : r < 5 ? 2'b10 : r < 6 ? 2'b11 : 2'b00;
            ja = $urandom;
            if (r[0]) ja[1:0] = 2'b00;
            step(s, ja);
        end

        // asynchronous reset in the middle of a burst
        #2;
        do_reset();
        repeat (60) begin
            int r = $urandom_range(99);
            s = r < 4 ? 2'b01 : r < 6 ? 2'b11 : 2'b00;
            step(s, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter TRAP_PC, default 32'h0000_0004, redirect target for TRAP.
REQ-003 SHALL have ports: clk  in  1  clock; one clock, all state on rising edge.
REQ-004 SHALL have port rst_n  in  1  reset; asynchronous, active-low.
REQ-005 SHALL have port next_pc_sel  in  2 (nextPCType_e)  PC_PLUS4 = no redirect; JUMP = go to jump_addr; TRAP (2'b1?) = go to TRAP_PC.
REQ-006 SHALL have port jump_addr  in  32  JUMP target.
REQ-007 SHALL have ports imem_req out 1, imem_addr out 32, imem_gnt in 1: request is accepted when imem_req and imem_gnt are both high.
REQ-008 SHALL have ports imem_rvalid in 1, imem_rdata in 32: response returned in order, at least 1 cycle after acceptance.
REQ-009 SHALL have ports id_valid out 1, id_ready in 1, id_inst out 32 (instruction_u), id_pc out 32: decode handshake.
REQ-010 SHALL have port fetch_misaligned  out  1  one-cycle pulse on a misaligned JUMP target.

Function
REQ-011 SHALL hold pc (next request address) and a 2-entry FIFO of {pc, inst}; outstanding counter 0..2.
REQ-012 SHALL assert imem_req only in RUN when outstanding + FIFO occupancy < 2; imem_addr = pc.
REQ-013 SHALL on acceptance: pc <= pc+4 (modulo 2^32; 32'hFFFF_FFFC wraps to 0), outstanding++, and tag the request with pc.
REQ-014 SHALL push {tag, imem_rdata} on imem_rvalid unless the response is being discarded; outstanding--.
REQ-015 SHALL drive id_valid = FIFO not empty; id_inst/id_pc = FIFO head; pop when id_valid && id_ready.
REQ-016 SHALL allow push and pop in the same cycle when the FIFO is full; no overflow possible by REQ-012.
REQ-017 SHALL keep id_inst/id_pc stable while id_valid && !id_ready.
REQ-018 SHALL implement FSM IDLE -> RUN -> DRAIN -> RUN.
REQ-019 SHALL leave IDLE after exactly one cycle post-reset, with no request in IDLE.
REQ-020 SHALL on redirect (next_pc_sel != PC_PLUS4) in any state: load pc with target, clear FIFO, block any acceptance that cycle.
REQ-021 SHALL, on redirect, go to DRAIN if outstanding > 0 after this cycle, else RUN.
REQ-022 SHALL in DRAIN discard every rvalid, issue no request, and go to RUN when outstanding reaches 0.
REQ-023 SHALL complete a handshake that coincides with a redirect; decode consumes that instruction, and the FIFO is then flushed.
REQ-024 SHALL discard an rvalid coinciding with a redirect.
REQ-025 SHALL issue the target request the cycle after the redirect when outstanding is 0.
REQ-026 SHALL give TRAP priority semantics through the encoding only; 2'b10 and 2'b11 both select TRAP_PC.

Reset
REQ-027 SHALL on rst_n low, asynchronously: state=IDLE, pc=RESET_PC, FIFO empty, outstanding=0, imem_req=0, imem_addr=RESET_PC, id_valid=0, id_inst=0, id_pc=0, fetch_misaligned=0.
REQ-028 SHALL on reset mid-operation drop all in-flight responses; rvalid after reset release with outstanding=0 is ignored.

Configuration
REQ-029 SHALL, with IFETCH_MISALIGN_CHECK_EN defined and jump_addr[1:0] != 0 on JUMP: pulse fetch_misaligned and redirect to TRAP_PC.
REQ-030 SHALL, without IFETCH_MISALIGN_CHECK_EN: force the target to {jump_addr[31:2],2'b00} and tie fetch_misaligned to 0.

Structure
REQ-031 SHALL use nextPCType_e and instruction_u from package riscv_definitions; add a fetch FSM state enum there.
REQ-032 SHALL place the 2-entry FIFO in sub-module fetch_buffer (parameterised payload width, push/pop/flush/count).

Verification
REQ-033 Reset release, imem_gnt=1, rvalid 1 cycle later, id_ready=1 -> addresses 0,4,8 issued on consecutive cycles; id_pc 0,4,8 in order.
REQ-034 id_ready=0 -> at most 2 accepted requests, then imem_req=0; id_inst held stable; id_ready=1 resumes fetch.
REQ-035 JUMP to 32'h100 with 2 outstanding -> both responses dropped; first request to 32'h100 after outstanding=0; id_pc=32'h100 next.
REQ-036 TRAP (2'b11) -> next request address is TRAP_PC; FIFO empty next cycle.
REQ-037 JUMP to 32'h102 -> with macro: fetch_misaligned=1 one cycle, fetch at TRAP_PC; without macro: fetch at 32'h100.
REQ-038 pc=32'hFFFF_FFFC accepted -> next imem_addr=0; rst_n low mid-burst -> all outputs at REQ-027 values immediately.
